// File: rtl/shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : shift_register
//  Description : Serial-in / parallel-out shift register with parallel load.
//                Shifts left one bit per peripheral clock edge pulse, taking
//                the new LSB from serialDataIn; MSB drives serialDataOut.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             peripheralClkEdge,
    input  logic             parallelLoad,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             serialDataOut
);

    logic [WIDTH-1:0] r_shiftReg;

    // State update: reset beats load, load beats shift, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shiftReg <= '0;
        end else if (parallelLoad) begin
            r_shiftReg <= parallelDataIn;
        end else if (peripheralClkEdge) begin
            r_shiftReg <= {r_shiftReg[WIDTH-2:0], serialDataIn};
        end
    end

    // Outputs come straight from the register, so there is no input-to-output path.
    assign parallelDataOut = r_shiftReg;
    assign serialDataOut   = r_shiftReg[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_register
//  Description : Self-checking bench for shift_register (WIDTH = 8).
//                Table of vectors plus hand-written multi-cycle sequences;
//                expected values flow through a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_register;

    localparam int c_WIDTH = 8;

    typedef struct {
        string              name;
        logic               rstN;
        logic               load;
        logic               shEdge;
        logic [c_WIDTH-1:0] pdin;
        logic               sin;
        logic [c_WIDTH-1:0] exp;
    } vec_t;

    typedef struct {
        string              name;
        logic [c_WIDTH-1:0] exp;
    } sb_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               peripheralClkEdge;
    logic               parallelLoad;
    logic [c_WIDTH-1:0] parallelDataIn;
    logic               serialDataIn;
    logic [c_WIDTH-1:0] parallelDataOut;
    logic               serialDataOut;

    int  testsRun  = 0;
    int  failCount = 0;
    sb_t scoreboard[$];
    vec_t vecs[$];

    shift_register #(.WIDTH(c_WIDTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .peripheralClkEdge (peripheralClkEdge),
        .parallelLoad      (parallelLoad),
        .parallelDataIn    (parallelDataIn),
        .serialDataIn      (serialDataIn),
        .parallelDataOut   (parallelDataOut),
        .serialDataOut     (serialDataOut)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic r, logic l, logic e,
                                logic [c_WIDTH-1:0] d, logic s,
                                logic [c_WIDTH-1:0] x);
        vec_t v;
        v.name = n; v.rstN = r; v.load = l; v.shEdge = e;
        v.pdin = d; v.sin = s; v.exp = x;
        return v;
    endfunction

    task automatic check(string n, logic [c_WIDTH-1:0] exp);
        testsRun++;
        if (parallelDataOut !== exp || serialDataOut !== exp[c_WIDTH-1]) begin
            failCount++;
            $display("FAIL %s: got pdo=%h sdo=%b, expected pdo=%h sdo=%b",
                     n, parallelDataOut, serialDataOut, exp, exp[c_WIDTH-1]);
        end
    endtask

    // Drive one cycle at negedge, queue the expectation, compare after posedge.
    task automatic applyCycle(string n, logic r, logic l, logic e,
                              logic [c_WIDTH-1:0] d, logic s,
                              logic [c_WIDTH-1:0] x);
        sb_t item;
        @(negedge clk);
        rst_n = r; parallelLoad = l; peripheralClkEdge = e;
        parallelDataIn = d; serialDataIn = s;
        item.name = n; item.exp = x;
        scoreboard.push_back(item);
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            testsRun++; failCount++;
            $display("FAIL %s: scoreboard empty, expected one entry", n);
        end else begin
            item = scoreboard.pop_front();
            check(item.name, item.exp);
        end
    endtask

    initial begin
        logic [c_WIDTH-1:0] model;
        logic [c_WIDTH-1:0] pattern;
        logic               bitV;

        rst_n = 1'b1; parallelLoad = 1'b0; peripheralClkEdge = 1'b0;
        parallelDataIn = '0; serialDataIn = 1'b0;

        // rstN load edge pdin sin expected
        vecs.push_back(mk("reset",          0, 0, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk("load80",         1, 1, 0, 8'h80, 0, 8'h80));
        vecs.push_back(mk("shift_in1",      1, 0, 1, 8'h00, 1, 8'h01));
        vecs.push_back(mk("gated_hold",     1, 0, 0, 8'h00, 1, 8'h01));
        vecs.push_back(mk("load_beats_sh",  1, 1, 1, 8'hA5, 1, 8'hA5));
        vecs.push_back(mk("hold_pdin_chg",  1, 0, 0, 8'h3C, 0, 8'hA5));
        vecs.push_back(mk("loadFF",         1, 1, 0, 8'hFF, 0, 8'hFF));
        vecs.push_back(mk("reset_over_ld",  0, 1, 0, 8'h5A, 0, 8'h00));
        vecs.push_back(mk("fill1",          1, 0, 1, 8'h00, 1, 8'h01));
        vecs.push_back(mk("fill2",          1, 0, 1, 8'h00, 0, 8'h02));
        vecs.push_back(mk("fill3",          1, 0, 1, 8'h00, 1, 8'h05));
        vecs.push_back(mk("fill4",          1, 0, 1, 8'h00, 1, 8'h0B));
        vecs.push_back(mk("fill5",          1, 0, 1, 8'h00, 0, 8'h16));
        vecs.push_back(mk("fill6",          1, 0, 1, 8'h00, 0, 8'h2C));
        vecs.push_back(mk("fill7",          1, 0, 1, 8'h00, 1, 8'h59));
        vecs.push_back(mk("fill8_B2",       1, 0, 1, 8'h00, 0, 8'hB2));
        vecs.push_back(mk("msb_discard",    1, 0, 1, 8'h00, 0, 8'h64));
        vecs.push_back(mk("reset_over_sh",  0, 0, 1, 8'h00, 1, 8'h00));

        foreach (vecs[i])
            applyCycle(vecs[i].name, vecs[i].rstN, vecs[i].load, vecs[i].shEdge,
                       vecs[i].pdin, vecs[i].sin, vecs[i].exp);

        // Reset in the middle of a shift sequence discards partial data.
        applyCycle("mid_load3C", 1, 1, 0, 8'h3C, 0, 8'h3C);
        applyCycle("mid_sh1",    1, 0, 1, 8'h00, 1, 8'h79);
        applyCycle("mid_sh2",    1, 0, 1, 8'h00, 0, 8'hF2);
        applyCycle("mid_reset",  0, 0, 1, 8'h00, 1, 8'h00);
        applyCycle("post_reset", 1, 0, 0, 8'h00, 1, 8'h00);

        // Inputs changing between edges must not reach the outputs.
        applyCycle("pre_glitch", 1, 1, 0, 8'hC3, 0, 8'hC3);
        @(negedge clk);
        parallelLoad = 1'b1; parallelDataIn = 8'h0F;
        peripheralClkEdge = 1'b1; serialDataIn = 1'b1;
        #2;
        check("no_comb_path", 8'hC3);
        parallelLoad = 1'b0; peripheralClkEdge = 1'b0;
        #1;
        @(posedge clk); #1;
        check("glitch_no_effect", 8'hC3);

        // Serial fill of a random word: earliest bit ends in the MSB.
        pattern = 8'($urandom_range(0, 255));
        model   = 8'hC3;
        for (int k = c_WIDTH - 1; k >= 0; k--) begin
            bitV  = pattern[k];
            model = {model[c_WIDTH-2:0], bitV};
            applyCycle("rand_fill", 1, 0, 1, 8'h00, bitV, model);
        end
        testsRun++;
        if (parallelDataOut !== pattern) begin
            failCount++;
            $display("FAIL rand_fill_word: got %h, expected %h", parallelDataOut, pattern);
        end

        if (scoreboard.size() != 0) begin
            testsRun++; failCount++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", scoreboard.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_register.md
SHIFT_REGISTER -- requirements
Module: shift_register

Interface
REQ-001 The block SHALL have one parameter: width, default 8, meaning the number of register bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port peripheralClkEdge, input, 1 bit: a one-cycle shift enable, pulsed by upstream edge detection of the peripheral serial clock.
REQ-005 The block SHALL have port parallelLoad, input, 1 bit: when high, the register loads parallelDataIn.
REQ-006 The block SHALL have port parallelDataIn, input, width bits: the parallel load value.
REQ-007 The block SHALL have port serialDataIn, input, 1 bit: the serial bit shifted into the LSB.
REQ-008 The block SHALL have port parallelDataOut, output, width bits: the full register contents.
REQ-009 The block SHALL have port serialDataOut, output, 1 bit: the register MSB.

Function
REQ-010 The block SHALL hold one width-bit state register, called shiftreg below.
REQ-011 parallelDataOut SHALL equal shiftreg combinationally, with no added latency.
REQ-012 serialDataOut SHALL equal shiftreg[width-1] combinationally.
REQ-013 On each rising clk edge, shiftreg SHALL update by strict priority:
- rst_n=0: clear to 0.
- else parallelLoad=1: load parallelDataIn.
- else peripheralClkEdge=1: shift left, new value {shiftreg[width-2:0], serialDataIn}.
- else: hold.
REQ-014 Load and shift SHALL each take effect in exactly one clk cycle; the new value is visible on the outputs immediately after that edge.
REQ-015 When parallelLoad=1 and peripheralClkEdge=1 in the same cycle, the load SHALL win and no shift SHALL occur in that cycle.
REQ-016 serialDataIn SHALL be sampled only at clk edges where a shift occurs; it is ignored otherwise.
REQ-017 A shift SHALL discard the old MSB; no overflow indication exists.
REQ-018 Consecutive shift cycles SHALL each shift by exactly one bit; after width shifts, the register holds the last width serial bits, the earliest bit in the MSB.
REQ-019 The block SHALL contain no combinational path from inputs to outputs.
REQ-020 Between rising clk edges, input changes SHALL have no effect on the outputs.

Reset
REQ-021 When rst_n=0 is sampled at a rising clk edge, shiftreg SHALL become 0, so parallelDataOut=0 and serialDataOut=0.
REQ-022 Reset SHALL override parallelLoad and peripheralClkEdge in the same cycle.
REQ-023 Reset asserted in the middle of a shift sequence SHALL discard all partial data.
REQ-024 Contents before the first reset SHALL be undefined; benches SHALL apply reset before checking.
REQ-025 Deasserting rst_n SHALL have no effect until the next rising clk edge.

Verification
REQ-026 Parallel load: rst_n=1, parallelLoad=1, parallelDataIn=8'h80, one clk -> parallelDataOut=8'h80, serialDataOut=1.
REQ-027 Shift: from 8'h80, parallelLoad=0, peripheralClkEdge=1, serialDataIn=1, one clk -> parallelDataOut=8'h01, serialDataOut=0.
REQ-028 Shift gating: from 8'h01, peripheralClkEdge=0, serialDataIn=1, one clk -> parallelDataOut stays 8'h01, serialDataOut=0.
REQ-029 Priority: from 8'h01, parallelLoad=1, peripheralClkEdge=1, parallelDataIn=8'hA5, one clk -> 8'hA5.
REQ-030 Serial fill: from 0, shift the 8 bits 1,0,1,1,0,0,1,0 one per clk -> 8'hB2, serialDataOut=1.
REQ-031 Reset: from 8'hFF, rst_n=0 with parallelLoad=1, one clk -> parallelDataOut=8'h00, serialDataOut=0.
